// File: rtl/commit_pkg.sv
// Shared types and constants for the commit tracker: data widths, the ebreak
// encoding, tracked CSR indices and the buffered commit entry layout.
package commit_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NCSR = 5;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  localparam logic [2:0] CSR_MSTATUS  = 3'd0;
  localparam logic [2:0] CSR_MTVEC    = 3'd1;
  localparam logic [2:0] CSR_MEPC     = 3'd2;
  localparam logic [2:0] CSR_MCAUSE   = 3'd3;
  localparam logic [2:0] CSR_MSCRATCH = 3'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            rd_wen;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic            csr_wen;
    logic [2:0]      csr_idx;
    logic [XLEN-1:0] csr_data;
    logic            skip;
  } commit_entry_t;

endpackage

// File: rtl/commit_tracker_if.sv
// Commit-in / report-out bundle for commit_tracker. The master side is the
// pipeline plus the difftest bridge; the slave side is the tracker itself.
// Optional macro COMMIT_TRAP_EN adds the halt / halt_code report signals.
interface commit_tracker_if;
  import commit_pkg::*;

  logic                 cm_valid;
  logic                 cm_ready;
  logic [XLEN-1:0]      cm_pc;
  logic [31:0]          cm_inst;
  logic                 cm_rd_wen;
  logic [4:0]           cm_rd;
  logic [XLEN-1:0]      cm_rd_data;
  logic                 cm_csr_wen;
  logic [2:0]           cm_csr_idx;
  logic [XLEN-1:0]      cm_csr_data;
  logic                 cm_skip;

  logic                 rp_ready;
  logic                 rp_valid;
  logic [XLEN-1:0]      rp_pc;
  logic [31:0]          rp_inst;
  logic                 rp_skip;
  logic [32*XLEN-1:0]   rp_gpr;
  logic [NCSR*XLEN-1:0] rp_csr;
  logic [XLEN-1:0]      rp_count;

`ifdef COMMIT_TRAP_EN
  logic                 halt;
  logic [XLEN-1:0]      halt_code;

  modport master (
    output cm_valid, cm_pc, cm_inst, cm_rd_wen, cm_rd, cm_rd_data, cm_csr_wen, cm_csr_idx,
           cm_csr_data, cm_skip, rp_ready,
    input  cm_ready, rp_valid, rp_pc, rp_inst, rp_skip, rp_gpr, rp_csr, rp_count, halt,
           halt_code
  );

  modport slave (
    input  cm_valid, cm_pc, cm_inst, cm_rd_wen, cm_rd, cm_rd_data, cm_csr_wen, cm_csr_idx,
           cm_csr_data, cm_skip, rp_ready,
    output cm_ready, rp_valid, rp_pc, rp_inst, rp_skip, rp_gpr, rp_csr, rp_count, halt,
           halt_code
  );
`else
  modport master (
    output cm_valid, cm_pc, cm_inst, cm_rd_wen, cm_rd, cm_rd_data, cm_csr_wen, cm_csr_idx,
           cm_csr_data, cm_skip, rp_ready,
    input  cm_ready, rp_valid, rp_pc, rp_inst, rp_skip, rp_gpr, rp_csr, rp_count
  );

  modport slave (
    input  cm_valid, cm_pc, cm_inst, cm_rd_wen, cm_rd, cm_rd_data, cm_csr_wen, cm_csr_idx,
           cm_csr_data, cm_skip, rp_ready,
    output cm_ready, rp_valid, rp_pc, rp_inst, rp_skip, rp_gpr, rp_csr, rp_count
  );
`endif

endinterface

// File: rtl/commit_fifo.sv
// Synchronous FIFO of commit entries. Pointers carry one extra wrap bit so
// full/empty come straight from the registered pointers.
module commit_fifo
  import commit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  commit_entry_t wdata_i,
  input  logic          pop_i,
  output commit_entry_t rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  commit_entry_t mem_q [DEPTH];

  // Status flags and pointer advance.
  always_comb begin
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_o  = (wr_ptr_q == rd_ptr_q);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i && !full_o) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/commit_tracker.sv
// Buffers in-order commit events, replays them into a shadow GPR/CSR file and
// emits one registered report per commit. Optional macro COMMIT_TRAP_EN adds a
// sticky halt on ebreak that freezes further reports.
module commit_tracker
  import commit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  commit_tracker_if.slave bus
);

  commit_entry_t wr_entry, rd_entry;
  logic          full, empty, push, pop;

  logic [31:0][XLEN-1:0]   gpr_q, gpr_d;
  logic [NCSR-1:0][XLEN-1:0] csr_q, csr_d;
  logic                    rp_valid_q;
  logic [XLEN-1:0]         rp_pc_q;
  logic [31:0]             rp_inst_q;
  logic                    rp_skip_q;
  logic [XLEN-1:0]         rp_count_q;

`ifdef COMMIT_TRAP_EN
  logic                    halt_q;
  logic [XLEN-1:0]         halt_code_q;
`endif

  // Pack the incoming commit into a FIFO entry.
  always_comb begin
    wr_entry          = '0;
    wr_entry.pc       = bus.cm_pc;
    wr_entry.inst     = bus.cm_inst;
    wr_entry.rd_wen   = bus.cm_rd_wen;
    wr_entry.rd       = bus.cm_rd;
    wr_entry.rd_data  = bus.cm_rd_data;
    wr_entry.csr_wen  = bus.cm_csr_wen;
    wr_entry.csr_idx  = bus.cm_csr_idx;
    wr_entry.csr_data = bus.cm_csr_data;
    wr_entry.skip     = bus.cm_skip;
  end

  assign bus.cm_ready = !full;
  assign push         = bus.cm_valid && !full;
`ifdef COMMIT_TRAP_EN
  assign pop          = !empty && bus.rp_ready && !halt_q;
`else
  assign pop          = !empty && bus.rp_ready;
`endif

  commit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (rd_entry),
    .full_o  (full),
    .empty_o (empty)
  );

  // Shadow state after applying the entry being popped; x0 stays zero.
  always_comb begin
    gpr_d = gpr_q;
    csr_d = csr_q;
    if (pop) begin
      if (rd_entry.rd_wen && (rd_entry.rd != 5'd0)) gpr_d[rd_entry.rd] = rd_entry.rd_data;
      if (rd_entry.csr_wen && (32'(rd_entry.csr_idx) < NCSR)) begin
        csr_d[rd_entry.csr_idx] = rd_entry.csr_data;
      end
    end
  end

  // Shadow state and report registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr_q      <= '0;
      csr_q      <= '0;
      rp_valid_q <= 1'b0;
      rp_pc_q    <= '0;
      rp_inst_q  <= '0;
      rp_skip_q  <= 1'b0;
      rp_count_q <= '0;
    end else begin
      gpr_q      <= gpr_d;
      csr_q      <= csr_d;
      rp_valid_q <= pop;
      if (pop) begin
        rp_pc_q    <= rd_entry.pc;
        rp_inst_q  <= rd_entry.inst;
        rp_skip_q  <= rd_entry.skip;
        rp_count_q <= rp_count_q + 1'b1;
      end
    end
  end

`ifdef COMMIT_TRAP_EN
  // Sticky halt on ebreak, capturing a0 as it stands after that commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q      <= 1'b0;
      halt_code_q <= '0;
    end else if (pop && (rd_entry.inst == EBREAK_INST)) begin
      halt_q      <= 1'b1;
      halt_code_q <= gpr_d[10];
    end
  end

  assign bus.halt      = halt_q;
  assign bus.halt_code = halt_code_q;
`endif

  assign bus.rp_valid = rp_valid_q;
  assign bus.rp_pc    = rp_pc_q;
  assign bus.rp_inst  = rp_inst_q;
  assign bus.rp_skip  = rp_skip_q;
  assign bus.rp_count = rp_count_q;
  assign bus.rp_gpr   = gpr_q;
  assign bus.rp_csr   = csr_q;

endmodule

// File: tb/tb_commit_tracker.sv
// Scoreboard bench for commit_tracker: a queue-based reference model predicts
// acceptance, report timing and post-commit architectural state; a negedge
// monitor compares the DUT against it.
module tb_commit_tracker;
  import commit_pkg::*;

  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  commit_tracker_if bus ();

  commit_tracker #(
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [31:0]          inst;
    logic                 skip;
    logic [32*XLEN-1:0]   gpr;
    logic [NCSR*XLEN-1:0] csr;
    logic [XLEN-1:0]      count;
  } rep_t;

  typedef struct packed {
    logic            ebk;
    logic [XLEN-1:0] a0;
  } pend_t;

  rep_t            sb_q[$];
  pend_t           pend[$];
  logic [XLEN-1:0] m_gpr [32];
  logic [XLEN-1:0] m_csr [NCSR];
  logic [XLEN-1:0] m_count;
  logic [XLEN-1:0] m_halt_code;
  bit              m_halt;
  bit              exp_valid;

  int n_vec = 0;
  int n_err = 0;
  int n_dut_rep = 0;
  int base;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    pend.delete();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    for (int i = 0; i < NCSR; i++) m_csr[i] = '0;
    m_count     = '0;
    m_halt      = 1'b0;
    m_halt_code = '0;
    exp_valid   = 1'b0;
  endtask

  // One clock of the reference: a commit accepted now gets its full post-commit
  // report computed immediately, since reports come out strictly in order.
  task automatic model_step();
    bit    do_pop, do_push;
    pend_t p;
    rep_t  r;
    do_pop  = (pend.size() > 0) && bus.rp_ready && !m_halt;
    do_push = bus.cm_valid && (pend.size() < DEPTH);
    exp_valid = do_pop;
    if (do_pop) begin
      p = pend.pop_front();
`ifdef COMMIT_TRAP_EN
      if (p.ebk) begin
        m_halt      = 1'b1;
        m_halt_code = p.a0;
      end
`endif
    end
    if (do_push) begin
      if (bus.cm_rd_wen && bus.cm_rd != 5'd0) m_gpr[bus.cm_rd] = bus.cm_rd_data;
      if (bus.cm_csr_wen && bus.cm_csr_idx < NCSR) m_csr[bus.cm_csr_idx] = bus.cm_csr_data;
      m_count = m_count + 1;
      r.pc    = bus.cm_pc;
      r.inst  = bus.cm_inst;
      r.skip  = bus.cm_skip;
      r.count = m_count;
      for (int i = 0; i < 32; i++) r.gpr[i*XLEN +: XLEN] = m_gpr[i];
      for (int i = 0; i < NCSR; i++) r.csr[i*XLEN +: XLEN] = m_csr[i];
      sb_q.push_back(r);
      p.ebk = (bus.cm_inst == EBREAK_INST);
      p.a0  = m_gpr[10];
      pend.push_back(p);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Monitor: handshake, report timing and report contents.
  initial begin
    rep_t r;
    forever begin
      @(negedge clk);
      if (bus.rp_valid) n_dut_rep++;
      chk("cm_ready", 64'(bus.cm_ready), 64'(pend.size() < DEPTH));
      chk("rp_valid", 64'(bus.rp_valid), 64'(exp_valid));
`ifdef COMMIT_TRAP_EN
      chk("halt", 64'(bus.halt), 64'(m_halt));
      chk("halt_code", bus.halt_code, m_halt_code);
`endif
      if (exp_valid) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard: report due but no expected entry at %0t", $time);
        end else begin
          r = sb_q.pop_front();
          chk("rp_pc", bus.rp_pc, r.pc);
          chk("rp_inst", 64'(bus.rp_inst), 64'(r.inst));
          chk("rp_skip", 64'(bus.rp_skip), 64'(r.skip));
          chk("rp_count", bus.rp_count, r.count);
          for (int i = 0; i < 32; i++)
            chk($sformatf("rp_gpr[%0d]", i), bus.rp_gpr[i*XLEN +: XLEN], r.gpr[i*XLEN +: XLEN]);
          for (int i = 0; i < NCSR; i++)
            chk($sformatf("rp_csr[%0d]", i), bus.rp_csr[i*XLEN +: XLEN], r.csr[i*XLEN +: XLEN]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cm_valid    = 1'b0;
    bus.cm_pc       = '0;
    bus.cm_inst     = '0;
    bus.cm_rd_wen   = 1'b0;
    bus.cm_rd       = '0;
    bus.cm_rd_data  = '0;
    bus.cm_csr_wen  = 1'b0;
    bus.cm_csr_idx  = '0;
    bus.cm_csr_data = '0;
    bus.cm_skip     = 1'b0;
  endtask

  task automatic drive(input logic [XLEN-1:0] pc, input logic [31:0] inst, input logic rwen,
                       input logic [4:0] rd, input logic [XLEN-1:0] rdata, input logic cwen,
                       input logic [2:0] cidx, input logic [XLEN-1:0] cdata, input logic skip);
    bus.cm_valid    = 1'b1;
    bus.cm_pc       = pc;
    bus.cm_inst     = inst;
    bus.cm_rd_wen   = rwen;
    bus.cm_rd       = rd;
    bus.cm_rd_data  = rdata;
    bus.cm_csr_wen  = cwen;
    bus.cm_csr_idx  = cidx;
    bus.cm_csr_data = cdata;
    bus.cm_skip     = skip;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rp_valid"}, 64'(bus.rp_valid), 64'd0);
    chk({tag, " rp_pc"}, bus.rp_pc, 64'd0);
    chk({tag, " rp_inst"}, 64'(bus.rp_inst), 64'd0);
    chk({tag, " rp_skip"}, 64'(bus.rp_skip), 64'd0);
    chk({tag, " rp_count"}, bus.rp_count, 64'd0);
    chk({tag, " rp_gpr nonzero"}, 64'(bus.rp_gpr != '0), 64'd0);
    chk({tag, " rp_csr nonzero"}, 64'(bus.rp_csr != '0), 64'd0);
    chk({tag, " cm_ready"}, 64'(bus.cm_ready), 64'd1);
`ifdef COMMIT_TRAP_EN
    chk({tag, " halt"}, 64'(bus.halt), 64'd0);
    chk({tag, " halt_code"}, bus.halt_code, 64'd0);
`endif
  endtask

  // Directed scenarios followed by a randomized phase.
  initial begin
    idle();
    bus.rp_ready = 1'b1;
    #2;
    chk_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single commit: report exactly two cycles after the enqueue edge.
    drive(64'h8000_0000, 32'h0050_0093, 1'b1, 5'd1, 64'd5, 1'b0, 3'd0, 64'd0, 1'b0);
    step();
    idle();
    @(negedge clk);
    chk("single early rp_valid", 64'(bus.rp_valid), 64'd0);
    @(negedge clk);
    chk("single rp_valid", 64'(bus.rp_valid), 64'd1);
    chk("single rp_pc", bus.rp_pc, 64'h8000_0000);
    chk("single gpr1", bus.rp_gpr[1*XLEN +: XLEN], 64'd5);
    chk("single rp_count", bus.rp_count, 64'd1);
    step();

    // x0 write is discarded but still reported.
    drive(64'h8000_0004, 32'h0000_0013, 1'b1, 5'd0, 64'hDEAD, 1'b0, 3'd0, 64'd0, 1'b0);
    step();
    idle();
    repeat (3) step();
    chk("x0 gpr0", bus.rp_gpr[0 +: XLEN], 64'd0);
    chk("x0 rp_count", bus.rp_count, 64'd2);

    // Backpressure: five offered, four accepted, then drained back-to-back.
    bus.rp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(64'h1000 + 64'(4 * i), 32'h0000_0013 + 32'(i), 1'b1, 5'(3 + i), 64'(100 + i),
            1'b0, 3'd0, 64'd0, 1'b0);
      step();
    end
    chk("bp cm_ready full", 64'(bus.cm_ready), 64'd0);
    idle();
    base = n_dut_rep;
    bus.rp_ready = 1'b1;
    repeat (6) step();
    chk("bp report count", 64'(n_dut_rep - base), 64'd4);
    chk("bp cm_ready drained", 64'(bus.cm_ready), 64'd1);

    // GPR and CSR in one entry, then an out-of-range CSR index.
    drive(64'h2000, 32'h3410_1073, 1'b1, 5'd2, 64'd7, 1'b1, CSR_MEPC, 64'h8000_0010, 1'b1);
    step();
    drive(64'h2004, 32'h0000_0013, 1'b0, 5'd0, 64'd0, 1'b1, 3'd6, 64'hFFFF, 1'b0);
    step();
    idle();
    repeat (4) step();
    chk("dual gpr2", bus.rp_gpr[2*XLEN +: XLEN], 64'd7);
    chk("dual mepc", bus.rp_csr[2*XLEN +: XLEN], 64'h8000_0010);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      bus.rp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0)
        drive({$urandom, $urandom}, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              {$urandom, $urandom}, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      else
        idle();
      step();
    end
    idle();
    bus.rp_ready = 1'b1;
    repeat (8) step();

    // Asynchronous reset with entries still queued.
    bus.rp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(64'h3000 + 64'(4 * i), 32'h0000_0013, 1'b1, 5'(20 + i), 64'(i + 1), 1'b0, 3'd0,
            64'd0, 1'b0);
      step();
    end
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    base = n_dut_rep;
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.rp_ready = 1'b1;
    repeat (6) step();
    chk("async no report", 64'(n_dut_rep - base), 64'd0);

`ifdef COMMIT_TRAP_EN
    // ebreak halts with a0 captured; the commit behind it stays queued.
    base = n_dut_rep;
    drive(64'h4000, 32'h0000_0513, 1'b1, 5'd10, 64'd0, 1'b0, 3'd0, 64'd0, 1'b0);
    step();
    drive(64'h4004, EBREAK_INST, 1'b0, 5'd0, 64'd0, 1'b0, 3'd0, 64'd0, 1'b0);
    step();
    drive(64'h4008, 32'h0090_0293, 1'b1, 5'd5, 64'd9, 1'b0, 3'd0, 64'd0, 1'b0);
    step();
    idle();
    repeat (8) step();
    chk("trap halt", 64'(bus.halt), 64'd1);
    chk("trap halt_code", bus.halt_code, 64'd0);
    chk("trap reports", 64'(n_dut_rep - base), 64'd2);
    chk("trap cm_ready", 64'(bus.cm_ready), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/commit_tracker.md
Name: commit_tracker

Overview:
- Sits between the core's writeback/commit stage and the simulation-side difftest bridge.
- Accepts in-order commit events from the pipeline through a valid/ready handshake and buffers them in a small FIFO.
- Replays them into a shadow architectural state of 32 GPRs and 5 CSRs.
- Emits one registered, self-consistent report per commit: pc, inst, skip flag, and the full state after that commit, for the bridge to hand to the reference model.

Parameters:
- DEPTH, 4, commit FIFO entries; power of two, ≥2.
- XLEN, 64, data width.
- NCSR, 5, number of tracked CSRs.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- cm_valid  in  1  commit event present
- cm_ready  out  1  FIFO can accept
- cm_pc  in  XLEN  committed pc
- cm_inst  in  32  committed instruction
- cm_rd_wen  in  1  GPR write
- cm_rd  in  5  GPR index
- cm_rd_data  in  XLEN  GPR value
- cm_csr_wen  in  1  CSR write
- cm_csr_idx  in  3  CSR index, 0..NCSR-1
- cm_csr_data  in  XLEN  CSR value
- cm_skip  in  1  reference model must skip (MMIO etc.)
- rp_ready  in  1  consumer can take a report
- rp_valid  out  1  report pulse
- rp_pc  out  XLEN
- rp_inst  out  32
- rp_skip  out  1
- rp_gpr  out  32*XLEN  flat; GPR i at [i*XLEN +: XLEN]
- rp_csr  out  NCSR*XLEN  flat, same packing
- rp_count  out  XLEN  total reports issued

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, FIFO empty, shadow GPR/CSR all 0, cm_ready=1.
- Enqueue: occurs when cm_valid && cm_ready.
- cm_ready rule: cm_ready = !full. Combinational from the registered count only, never from cm_valid.
- Pop:
  - Occurs when FIFO non-empty && rp_ready.
  - At most one pop per cycle.
  - Simultaneous push and pop on a full FIFO is not allowed, because cm_ready=0.
  - Simultaneous push and pop otherwise leaves the count unchanged.
- Pop effects at the clock edge:
  - Shadow GPR[rd] <= rd_data if rd_wen && rd!=0; writes to x0 are discarded.
  - Shadow CSR[idx] <= csr_data if csr_wen && idx<NCSR; idx≥NCSR is ignored.
  - A GPR write and a CSR write in the same entry are both applied.
  - rp_pc, rp_inst and rp_skip are loaded; rp_valid <= 1; rp_count increments.
- Report latency:
  - Minimum latency from enqueue to rp_valid is 2 cycles: write in cycle N, pop in N+1, rp_valid high in N+2.
  - Reports are strictly in commit order.
- rp_valid: high for exactly one cycle per pop, otherwise 0.
- rp_gpr / rp_csr: driven directly from the shadow registers, so the state shown alongside rp_valid already includes that commit.
- Pointer wrap: pointers are log2(DEPTH)+1 bits wide; full and empty are decided from the MSB compare.
- rp_ready low: pops stall and the FIFO fills; cm_ready drops when the count reaches DEPTH.
- rp_count: wraps modulo 2^XLEN.
- Reset mid-operation: in-flight entries are discarded with no partial report; every output returns to its reset value asynchronously.

Optional Feature:
- Macro: COMMIT_TRAP_EN.
- When defined, the block adds outputs halt (1) and halt_code (XLEN).
- Trigger: an entry with inst==32'h00100073 (ebreak) is popped.
- On trigger:
  - halt <= 1 and halt_code <= shadow GPR[10] value after that commit.
  - halt is sticky until reset.
  - While halt=1, pops are inhibited: remaining entries stay queued and no further reports are issued.
  - cm_ready follows the full rule.
- When not defined: no halt/halt_code ports, and ebreak is treated as an ordinary commit.

Decomposition:
- Shared package (commit_pkg):
  - XLEN and NCSR constants.
  - EBREAK_INST constant.
  - CSR index constants (MSTATUS=0, MTVEC=1, MEPC=2, MCAUSE=3, MSCRATCH=4).
  - commit_entry_t packed struct holding pc, inst, rd_wen, rd, rd_data, csr_wen, csr_idx, csr_data, skip.
- One sub-module, commit_fifo: a generic synchronous FIFO over commit_entry_t with push/pop/full/empty.
- Shadow-state update and report registers live in the top module.

Test Plan:
- Reset then single commit, with rp_ready=1: enqueue pc=0x80000000, inst=0x00500093, rd=1, data=5 -> rp_valid one cycle, exactly 2 cycles later; rp_pc=0x80000000; rp_gpr[1]=5; rp_count=1.
- x0 write: rd=0, data=0xDEAD -> report issued and rp_gpr[0] stays 0.
- Backpressure: hold rp_ready=0 and push 5 commits -> 4 accepted, cm_ready=0 after the 4th; release rp_ready -> 4 reports on consecutive cycles in order, then cm_ready=1.
- Dual write: rd=2, data=7, csr_idx=2 (mepc), data=0x80000010, skip=1 -> single report showing both updates and rp_skip=1; csr_idx=6 is ignored.
- Async reset mid-stream: assert rst_n=0 with 3 entries queued -> all outputs 0 immediately, no report after release.
- COMMIT_TRAP_EN: commit a0=0 (rd=10), then ebreak, then one more commit -> halt=1, halt_code=0, only 2 reports, third entry held.
